inst_fetch_ctrl: RTL and testbench

//  Sequences the instruction memory: owns the program counter, drives the memory's

---
 rtl/inst_fetch_ctrl_if.sv | 31 +++
 rtl/inst_fetch_ctrl.sv | 138 +++++++++++++
 tb/tb_inst_fetch_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_ctrl_if.sv
// Fetch-side bus bundle: combinational instruction-memory read port plus the
// valid/ready instruction stream toward decode.
interface inst_fetch_ctrl_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] inst_address;
    logic [DATA_W-1:0] read_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_inst;
    logic [ADDR_W-1:0] out_pc;

    modport master (
        output inst_address,
        input  read_data,
        output out_valid,
        input  out_ready,
        output out_inst,
        output out_pc
    );

    modport slave (
        input  inst_address,
        output read_data,
        input  out_valid,
        output out_ready,
        input  out_inst,
        input  out_pc
    );
endinterface

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, captures memory words into a
// one-entry output buffer, handles start, redirect-with-flush and halt.
module inst_fetch_ctrl #(
    parameter int         ADDR_W      = 16,
    parameter int         DATA_W      = 32,
    parameter int         DEPTH       = 256,
    parameter logic [3:0] HALT_OPCODE = 4'hF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   start_pc,
    inst_fetch_ctrl_if.master   bus,
    input  logic                redirect_valid,
    input  logic [ADDR_W-1:0]   redirect_target,
    output logic                busy,
    output logic                halted,
    output logic [15:0]         fetch_count
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t            state_r, state_s;
  logic [ADDR_W-1:0] pc_r, pc_s, pc_inc_s;
  logic [ADDR_W-1:0] out_pc_r, out_pc_s;
  logic [DATA_W-1:0] out_inst_r, out_inst_s;
  logic              out_valid_r, out_valid_s;
  logic [15:0]       count_r, count_s;
  logic              busy_r, halted_r;
  logic              redirect_s, load_s, xfer_s, is_halt_s;

  // Qualify redirect/load/transfer against the current state
  always_comb begin
    redirect_s = (state_r == ST_FETCH) && redirect_valid;
    load_s     = (state_r == ST_FETCH) && (!out_valid_r || bus.out_ready);
    // a redirect flushes the buffered word, so it never counts as delivered
    xfer_s     = out_valid_r && bus.out_ready && !redirect_s;
    is_halt_s  = (bus.read_data[31:28] == HALT_OPCODE);
    if (pc_r == ADDR_W'(DEPTH - 1)) begin
      pc_inc_s = {ADDR_W{1'b0}};
    end else begin
      pc_inc_s = pc_r + ADDR_W'(1);
    end
  end

  // Next-state, PC and output-buffer decisions
  always_comb begin
    state_s     = state_r;
    pc_s        = pc_r;
    out_valid_s = out_valid_r;
    out_inst_s  = out_inst_r;
    out_pc_s    = out_pc_r;
    if (xfer_s && (count_r != 16'hFFFF)) begin
      count_s = count_r + 16'd1;
    end else begin
      count_s = count_r;
    end
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s     = ST_FETCH;
          pc_s        = start_pc;
          out_valid_s = 1'b0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (redirect_s) begin
          pc_s        = redirect_target;
          out_valid_s = 1'b0;
        end else if (load_s) begin
          out_inst_s  = bus.read_data;
          out_pc_s    = pc_r;
          out_valid_s = 1'b1;
          if (is_halt_s) begin
            state_s = ST_HALTED;
          end else begin
            pc_s = pc_inc_s;
          end
        end else begin
          state_s = ST_FETCH;
        end
      end
      ST_HALTED: begin
        if (start) begin
          state_s     = ST_FETCH;
          pc_s        = start_pc;
          out_valid_s = 1'b0;
        end else if (xfer_s) begin
          out_valid_s = 1'b0;
        end else begin
          state_s = ST_HALTED;
        end
      end
      default: begin
        state_s     = ST_IDLE;
        out_valid_s = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      pc_r        <= {ADDR_W{1'b0}};
      out_valid_r <= 1'b0;
      out_inst_r  <= {DATA_W{1'b0}};
      out_pc_r    <= {ADDR_W{1'b0}};
      count_r     <= 16'd0;
      busy_r      <= 1'b0;
      halted_r    <= 1'b0;
    end else begin
      state_r     <= state_s;
      pc_r        <= pc_s;
      out_valid_r <= out_valid_s;
      out_inst_r  <= out_inst_s;
      out_pc_r    <= out_pc_s;
      count_r     <= count_s;
      busy_r      <= (state_s == ST_FETCH);
      halted_r    <= (state_s == ST_HALTED);
    end
  end

  assign bus.inst_address = pc_r;
  assign bus.out_valid    = out_valid_r;
  assign bus.out_inst     = out_inst_r;
  assign bus.out_pc       = out_pc_r;
  assign busy             = busy_r;
  assign halted           = halted_r;
  assign fetch_count      = count_r;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Bench for inst_fetch_ctrl: directed scenarios with literal expectations plus
// randomized traffic, all compared each cycle against a behavioural model.
module tb_inst_fetch_ctrl;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] start_pc;
  logic        redirect_valid;
  logic [15:0] redirect_target;
  logic        busy;
  logic        halted;
  logic [15:0] fetch_count;
  logic [31:0] mem [0:DEPTH-1];

  int checks   = 0;
  int failures = 0;

  // behavioural model: mode 0 idle, 1 fetching, 2 halted
  int          m_mode;
  int          m_pc;
  int          m_cnt;
  bit          m_bv;
  logic [31:0] m_bi;
  int          m_bp;
  bit          m_ok = 1'b0;

  inst_fetch_ctrl_if #(.ADDR_W(16), .DATA_W(32)) bus ();

  inst_fetch_ctrl #(.ADDR_W(16), .DATA_W(32), .DEPTH(DEPTH), .HALT_OPCODE(4'hF)) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .start_pc        (start_pc),
    .bus             (bus),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .busy            (busy),
    .halted          (halted),
    .fetch_count     (fetch_count)
  );

  always #5 clk = ~clk;

  assign bus.read_data = mem[bus.inst_address[7:0]];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_step();
    bit          xfer;
    logic [31:0] w;
    if (reset) begin
      m_mode = 0; m_pc = 0; m_cnt = 0; m_bv = 1'b0; m_bi = 32'd0; m_bp = 0;
      m_ok = 1'b1;
    end else begin
      xfer = m_bv && bus.out_ready && !(m_mode == 1 && redirect_valid);
      if (xfer && m_cnt < 65535) m_cnt = m_cnt + 1;
      if (m_mode == 0) begin
        if (start) begin m_mode = 1; m_pc = int'(start_pc); m_bv = 1'b0; end
      end else if (m_mode == 1) begin
        if (redirect_valid) begin
          m_pc = int'(redirect_target);
          m_bv = 1'b0;
        end else if (!m_bv || bus.out_ready) begin
          w    = mem[m_pc % DEPTH];
          m_bi = w;
          m_bp = m_pc;
          m_bv = 1'b1;
          if (w[31:28] == 4'hF) m_mode = 2;
          else m_pc = (m_pc + 1) % DEPTH;
        end
      end else begin
        if (start) begin m_mode = 1; m_pc = int'(start_pc); m_bv = 1'b0; end
        else if (xfer) m_bv = 1'b0;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // per-cycle comparison against the model, away from the active edge
  initial forever begin
    @(negedge clk);
    if (m_ok) begin
      chk("m_inst_address", 32'(bus.inst_address), 32'(m_pc));
      chk("m_out_valid", 32'(bus.out_valid), 32'(m_bv));
      chk("m_busy", 32'(busy), 32'(m_mode == 1));
      chk("m_halted", 32'(halted), 32'(m_mode == 2));
      chk("m_fetch_count", 32'(fetch_count), 32'(m_cnt));
      if (m_bv) begin
        chk("m_out_inst", bus.out_inst, m_bi);
        chk("m_out_pc", 32'(bus.out_pc), 32'(m_bp));
      end
    end
  end

  initial begin
    reset = 1'b1; start = 1'b0; start_pc = 16'd0;
    redirect_valid = 1'b0; redirect_target = 16'd0; bus.out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'(i);
    for (int i = 0; i < 6; i++) mem[i] = 32'h10 + 32'(i);
    tick(); tick();
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_count", 32'(fetch_count), 32'd0);
    chk("rst_addr", 32'(bus.inst_address), 32'd0);

    // streaming from 0 with decode always ready
    reset = 1'b0; bus.out_ready = 1'b1; start = 1'b1; start_pc = 16'd0;
    tick(); start = 1'b0;
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_valid_c1", 32'(bus.out_valid), 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t1_inst", bus.out_inst, 32'h10 + 32'(k));
      chk("t1_pc", 32'(bus.out_pc), 32'(k));
    end
    tick();
    chk("t1_count", 32'(fetch_count), 32'd4);

    // stall: buffer and PC frozen
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t2_inst", bus.out_inst, 32'h14);
      chk("t2_pc", 32'(bus.out_pc), 32'd4);
      chk("t2_addr", 32'(bus.inst_address), 32'd5);
      chk("t2_count", 32'(fetch_count), 32'd4);
    end
    bus.out_ready = 1'b1;
    tick();
    chk("t2_next_inst", bus.out_inst, 32'h15);
    chk("t2_next_pc", 32'(bus.out_pc), 32'd5);
    chk("t2_next_count", 32'(fetch_count), 32'd5);

    // redirect drops the ready word
    mem[8'h40] = 32'h0000_0040;
    redirect_valid = 1'b1; redirect_target = 16'h0040;
    tick(); redirect_valid = 1'b0;
    chk("t3_valid", 32'(bus.out_valid), 32'd0);
    chk("t3_addr", 32'(bus.inst_address), 32'h40);
    chk("t3_count", 32'(fetch_count), 32'd5);
    tick();
    chk("t3_pc", 32'(bus.out_pc), 32'h40);
    chk("t3_inst", bus.out_inst, 32'h40);

    // halt at word 5, then restart at 8
    reset = 1'b1; tick(); reset = 1'b0;
    mem[5] = 32'hF000_0000;
    start = 1'b1; start_pc = 16'd0;
    tick(); start = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    chk("t4_halted", 32'(halted), 32'd1);
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_pc", 32'(bus.out_pc), 32'd5);
    chk("t4_inst", bus.out_inst, 32'hF000_0000);
    chk("t4_valid", 32'(bus.out_valid), 32'd1);
    chk("t4_count", 32'(fetch_count), 32'd5);
    tick();
    chk("t4_valid_after", 32'(bus.out_valid), 32'd0);
    chk("t4_addr", 32'(bus.inst_address), 32'd5);
    chk("t4_count_after", 32'(fetch_count), 32'd6);
    start = 1'b1; start_pc = 16'd8;
    tick(); start = 1'b0;
    chk("t4_restart_busy", 32'(busy), 32'd1);
    chk("t4_restart_addr", 32'(bus.inst_address), 32'd8);
    tick();
    chk("t4_restart_pc", 32'(bus.out_pc), 32'd8);

    // wrap at DEPTH-1
    reset = 1'b1; tick(); reset = 1'b0;
    mem[254] = 32'h0000_00FE; mem[255] = 32'h0000_00FF;
    start = 1'b1; start_pc = 16'd254;
    tick(); start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t5_pc", 32'(bus.out_pc), 32'((254 + k) % DEPTH));
    end

    // reset mid-stream, start ignored while reset high
    reset = 1'b1; start = 1'b1; start_pc = 16'd3;
    tick();
    chk("t6_valid", 32'(bus.out_valid), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_count", 32'(fetch_count), 32'd0);
    tick();
    chk("t6_busy_hold", 32'(busy), 32'd0);
    chk("t6_addr", 32'(bus.inst_address), 32'd0);
    reset = 1'b0; start = 1'b0;
    tick();
    chk("t6_idle", 32'(busy), 32'd0);

    // randomized traffic against the model
    reset = 1'b1;
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    tick();
    for (int n = 0; n < 4000; n++) begin
      reset           = ($urandom_range(0, 299) == 0);
      start           = ($urandom_range(0, 7) == 0);
      start_pc        = 16'($urandom_range(0, DEPTH - 1));
      redirect_valid  = ($urandom_range(0, 15) == 0);
      redirect_target = 16'($urandom_range(0, DEPTH - 1));
      bus.out_ready   = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
